// File: rtl/ps2_rx_frame_if.sv
// Receiver-to-consumer bundle for decoded PS/2 scancodes.
// The receiver drives it as master; downstream logic reads it as slave.
interface ps2_rx_frame_if;
  logic [7:0] scancode;
  logic       new_code;
  logic       parity_err;
  logic       frame_err;
  logic       busy;

  modport master (
    output scancode,
    output new_code,
    output parity_err,
    output frame_err,
    output busy
  );

  modport slave (
    input scancode,
    input new_code,
    input parity_err,
    input frame_err,
    input busy
  );
endinterface

// File: rtl/ps2_rx_frame.sv
// PS/2 device-to-host frame receiver: sync, glitch filter, 11-bit deframer.
// Delivers good bytes with a strobe and flags parity/framing/timeout faults.
module ps2_rx_frame #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    ps2_clk,
  input  logic    ps2_data,
  ps2_rx_frame_if.master rx
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } state_t;

  logic [1:0]    clk_sync;
  logic [1:0]    dat_sync;
  logic          fclk;
  logic          fclk_d;
  logic          fall;
  logic [FW-1:0] fcnt;

  state_t        state;
  logic [2:0]    bitcnt;
  logic [7:0]    sr;
  logic          par;
  logic [TW-1:0] wdog;
  logic [7:0]    scancode;
  logic          new_code;
  logic          parity_err;
  logic          frame_err;
  logic          busy;

  wire din = dat_sync[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk};
      dat_sync <= {dat_sync[0], ps2_data};
    end
  end

  // fclk follows the pin only after FILTER_LEN disagreeing samples in a row
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fclk   <= 1'b1;
      fclk_d <= 1'b1;
      fall   <= 1'b0;
      fcnt   <= '0;
    end else begin
      fclk_d <= fclk;
      fall   <= fclk_d & ~fclk;
      if (clk_sync[1] == fclk) begin
        fcnt <= '0;
      end else if (fcnt == FW'(FILTER_LEN - 1)) begin
        fclk <= clk_sync[1];
        fcnt <= '0;
      end else begin
        fcnt <= fcnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      bitcnt     <= '0;
      sr         <= '0;
      par        <= 1'b0;
      wdog       <= '0;
      scancode   <= '0;
      new_code   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      new_code   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      if (fall) begin
        wdog <= '0;
        case (state)
          IDLE: begin
            if (!din) begin
              state  <= DATA;
              bitcnt <= '0;
              busy   <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
          end
          DATA: begin
            sr     <= {din, sr[7:1]};
            bitcnt <= bitcnt + 1'b1;
            if (bitcnt == 3'd7) state <= PARITY;
          end
          PARITY: begin
            par   <= din;
            state <= STOP;
          end
          STOP: begin
            state <= IDLE;
            busy  <= 1'b0;
            if (!din) begin
              frame_err <= 1'b1;
            end else if (!(^{sr, par})) begin
              parity_err <= 1'b1;
            end else begin
              scancode <= sr;
              new_code <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end else if (state != IDLE) begin
        // stalled frame: drop the partial byte
        if (wdog == TW'(TIMEOUT_CYCLES)) begin
          frame_err <= 1'b1;
          state     <= IDLE;
          busy      <= 1'b0;
          wdog      <= '0;
        end else begin
          wdog <= wdog + 1'b1;
        end
      end
    end
  end

  assign rx.scancode   = scancode;
  assign rx.new_code   = new_code;
  assign rx.parity_err = parity_err;
  assign rx.frame_err  = frame_err;
  assign rx.busy       = busy;

endmodule

// File: tb/tb_ps2_rx_frame.sv
// Directed bench for ps2_rx_frame: good, errored, timed-out,
// glitched and reset-interrupted frames with hand-computed results.
module tb_ps2_rx_frame;
  localparam int F  = 8;
  localparam int TO = 200;
  localparam int H  = 40;

  logic clk = 1'b0;
  logic rst_n;
  logic ps2_clk;
  logic ps2_data;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   nc_cnt = 0;
  int   pe_cnt = 0;
  int   fe_cnt = 0;
  int   nc_cyc = 0;
  int   stop_cyc = 0;
  int   n0, p0, f0;

  ps2_rx_frame_if bus ();

  ps2_rx_frame #(
    .FILTER_LEN     (F),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .rx       (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string tag, int obs, int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.new_code) begin
        nc_cnt++;
        nc_cyc = cyc;
      end
      if (bus.parity_err) pe_cnt++;
      if (bus.frame_err) fe_cnt++;
      if (bus.new_code | bus.parity_err | bus.frame_err)
        chk("onehot", $countones({bus.new_code, bus.parity_err, bus.frame_err}), 1);
    end
  end

  task automatic wait_cyc(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(logic b, bit glitch, bit last);
    ps2_data = b;
    if (glitch) begin
      wait_cyc(15);
      ps2_clk = 1'b0;
      wait_cyc(3);
      ps2_clk = 1'b1;
      wait_cyc(H - 18);
    end else begin
      wait_cyc(H);
    end
    ps2_clk = 1'b0;
    if (last) stop_cyc = cyc;
    wait_cyc(H);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(logic [7:0] d, bit pflip, bit stop,
                            bit glitch, int nbits);
    logic [10:0] fr;
    fr = {stop, ~(^d) ^ pflip, d, 1'b0};
    for (int i = 0; i < nbits; i++) send_bit(fr[i], glitch, i == 10);
    ps2_data = 1'b1;
    wait_cyc(F + 20);
  endtask

  task automatic snap();
    n0 = nc_cnt;
    p0 = pe_cnt;
    f0 = fe_cnt;
  endtask

  initial begin
    rst_n    = 1'b0;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    wait_cyc(5);
    chk("rst_scancode", bus.scancode, 0);
    chk("rst_new_code", bus.new_code, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_errs", {bus.parity_err, bus.frame_err}, 0);
    rst_n = 1'b1;
    wait_cyc(5);

    snap();
    ps2_clk = 1'b0;
    wait_cyc(F - 1);
    ps2_clk = 1'b1;
    wait_cyc(F + 20);
    chk("short_pulse_no_edge", fe_cnt, f0);
    ps2_clk = 1'b0;
    wait_cyc(F + 2);
    ps2_clk = 1'b1;
    wait_cyc(F + 20);
    chk("long_pulse_one_edge", fe_cnt, f0 + 1);
    chk("long_pulse_idle", bus.busy, 0);

    snap();
    send_frame(8'h1C, 0, 1, 0, 11);
    chk("good_nc", nc_cnt, n0 + 1);
    chk("good_code", bus.scancode, 'h1C);
    chk("good_latency", nc_cyc - stop_cyc, F + 4);
    chk("good_busy", bus.busy, 0);
    chk("good_errs", pe_cnt + fe_cnt, p0 + f0);

    snap();
    send_frame(8'hF0, 0, 1, 0, 11);
    chk("b2b_code0", bus.scancode, 'hF0);
    send_frame(8'h1C, 0, 1, 0, 11);
    chk("b2b_code1", bus.scancode, 'h1C);
    chk("b2b_nc", nc_cnt, n0 + 2);
    chk("b2b_errs", pe_cnt + fe_cnt, p0 + f0);

    snap();
    send_frame(8'h1C, 1, 1, 0, 11);
    chk("par_pe", pe_cnt, p0 + 1);
    chk("par_nc", nc_cnt, n0);
    chk("par_code", bus.scancode, 'h1C);

    snap();
    send_frame(8'h32, 0, 0, 0, 11);
    chk("stop_fe", fe_cnt, f0 + 1);
    chk("stop_pe", pe_cnt, p0);
    chk("stop_code", bus.scancode, 'h1C);

    snap();
    send_frame(8'h32, 0, 1, 0, 5);
    chk("to_busy_mid", bus.busy, 1);
    wait_cyc(TO + 10);
    chk("to_fe", fe_cnt, f0 + 1);
    chk("to_busy", bus.busy, 0);
    chk("to_code", bus.scancode, 'h1C);
    send_frame(8'h32, 0, 1, 0, 11);
    chk("to_next_code", bus.scancode, 'h32);
    chk("to_next_nc", nc_cnt, n0 + 1);

    snap();
    send_frame(8'h5A, 0, 1, 1, 11);
    chk("glitch_code", bus.scancode, 'h5A);
    chk("glitch_nc", nc_cnt, n0 + 1);
    chk("glitch_errs", pe_cnt + fe_cnt, p0 + f0);

    send_frame(8'h29, 0, 1, 0, 5);
    rst_n = 1'b0;
    wait_cyc(2);
    chk("mid_rst_code", bus.scancode, 0);
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_strobes",
        {bus.new_code, bus.parity_err, bus.frame_err}, 0);
    rst_n = 1'b1;
    wait_cyc(10);
    snap();
    send_frame(8'h29, 0, 1, 0, 11);
    chk("post_rst_code", bus.scancode, 'h29);
    chk("post_rst_nc", nc_cnt, n0 + 1);
    chk("post_rst_errs", pe_cnt + fe_cnt, p0 + f0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
